// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants, FSM encoding and command helper for the LCD text feeder
package lcd_pkg;
    localparam logic [7:0] LCD_CMD_SET_DDRAM = 8'h80;
    localparam logic [6:0] LCD_ROW0_BASE = 7'h00;
    localparam logic [6:0] LCD_ROW1_BASE = 7'h40;
    localparam logic [7:0] LCD_SPACE = 8'h20;
    localparam int LCD_SEQ_LEN = 34;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT_ACK = 3'd3;
    localparam logic [2:0] ST_WAIT_DONE = 3'd4;
    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        FETCH = ST_FETCH,
        ISSUE = ST_ISSUE,
        WAIT_ACK = ST_WAIT_ACK,
        WAIT_DONE = ST_WAIT_DONE
    } feeder_state_t;
    function automatic logic [8:0] ddram_cmd(input logic [6:0] base);
        return {1'b0, LCD_CMD_SET_DDRAM | {1'b0, base}};
    endfunction
endpackage

// File: rtl/lcd_char_buffer.sv
// lcd_char_buffer: screen image RAM with sync write, registered read and reset-to-space load
module lcd_char_buffer
    import lcd_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic       clock,
    input  logic       internal_reset_n,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data
);
    logic [7:0] mem [DEPTH];
    always_ff @(posedge clock) begin
        if (!internal_reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= LCD_SPACE;
            rd_data <= LCD_SPACE;
        end else begin
            if (wr_en) mem[wr_addr] <= wr_data;
            if (rd_en) rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/lcd_text_feeder.sv
// lcd_text_feeder: streams the 2-row screen image to the LCD driver as {rs,data} transactions
module lcd_text_feeder
    import lcd_pkg::*;
#(
    parameter int COLS = 16,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic       clock,
    input  logic       internal_reset_n,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       refresh_req,
    input  logic       lcd_busy,
    output logic [8:0] lcd_d,
    output logic       lcd_data_ready,
    output logic       feeder_busy
);
    localparam int TW = $clog2(ACK_TIMEOUT);
    localparam logic [5:0] ROW1_SEQ = 6'(COLS + 1);
    localparam logic [5:0] LAST_SEQ = 6'(LCD_SEQ_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
    feeder_state_t state;
    logic [5:0] seq;
    logic [TW-1:0] tmo;
    logic dirty;
    logic trigger;
    logic is_cmd;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    assign trigger = (dirty | refresh_req | wr_en) & ~lcd_busy;
    assign is_cmd = (seq == '0) | (seq == ROW1_SEQ);
    assign rd_addr = seq[4:0] - ((seq < ROW1_SEQ) ? 5'd1 : 5'd2);
    assign lcd_d = (state == IDLE) ? '0 :
                   is_cmd ? ddram_cmd((seq == '0) ? LCD_ROW0_BASE : LCD_ROW1_BASE) :
                   {1'b1, rd_data};
    assign lcd_data_ready = state == ISSUE;
    assign feeder_busy = state != IDLE;
    lcd_char_buffer #(.DEPTH(2 * COLS)) u_buf (
        .clock(clock),
        .internal_reset_n(internal_reset_n),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_en(state == FETCH),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );
    always_ff @(posedge clock) begin
        if (!internal_reset_n) begin
            state <= IDLE;
            seq <= '0;
            tmo <= '0;
            dirty <= 1'b1;
        end else begin
            dirty <= (state == IDLE && trigger) ? 1'b0 : (dirty | wr_en | refresh_req);
            case (state)
                IDLE: if (trigger) begin
                    state <= FETCH;
                    seq <= '0;
                end
                FETCH: state <= ISSUE;
                ISSUE: begin
                    state <= WAIT_ACK;
                    tmo <= '0;
                end
                WAIT_ACK: if (lcd_busy) state <= WAIT_DONE;
                    else if (tmo == TMO_LAST) state <= ISSUE;
                    else tmo <= tmo + TW'(1);
                WAIT_DONE: if (!lcd_busy) begin
                    state <= (seq == LAST_SEQ) ? IDLE : FETCH;
                    seq <= (seq == LAST_SEQ) ? seq : seq + 6'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_text_feeder.sv
// tb_lcd_text_feeder: directed bench with a behavioural LCD driver model
module tb_lcd_text_feeder;
    localparam int ACK = 1024;
    logic clock = 0;
    logic internal_reset_n = 0;
    logic wr_en = 0;
    logic [4:0] wr_addr = 0;
    logic [7:0] wr_data = 0;
    logic refresh_req = 0;
    logic lcd_busy;
    logic [8:0] lcd_d;
    logic lcd_data_ready;
    logic feeder_busy;
    logic model_busy = 0;
    logic force_busy = 1;
    logic ack_en = 1;
    int delay_cnt = 0;
    int hold_cnt = 0;
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    logic [8:0] pulses[$];
    int pcyc[$];
    logic [7:0] exp_buf[32];
    assign lcd_busy = model_busy | force_busy;
    always #5 clock = ~clock;
    lcd_text_feeder #(.COLS(16), .ACK_TIMEOUT(ACK)) dut (
        .clock(clock),
        .internal_reset_n(internal_reset_n),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .refresh_req(refresh_req),
        .lcd_busy(lcd_busy),
        .lcd_d(lcd_d),
        .lcd_data_ready(lcd_data_ready),
        .feeder_busy(feeder_busy)
    );
    always @(posedge clock) cyc <= cyc + 1;
    always @(posedge clock) begin
        if (hold_cnt > 0) begin
            hold_cnt <= hold_cnt - 1;
            if (hold_cnt == 1) model_busy <= 0;
        end else if (delay_cnt > 0) begin
            delay_cnt <= delay_cnt - 1;
            if (delay_cnt == 1) begin
                model_busy <= 1;
                hold_cnt <= 40;
            end
        end else if (lcd_data_ready && ack_en) delay_cnt <= 3;
    end
    always @(negedge clock) begin
        if (lcd_data_ready) begin
            pulses.push_back(lcd_d);
            pcyc.push_back(cyc);
        end
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    function automatic logic [8:0] exp_at(input int k);
        if (k == 0) return 9'h080;
        if (k == 17) return 9'h0C0;
        return {1'b1, exp_buf[(k < 17) ? k - 1 : k - 2]};
    endfunction
    task automatic check_refresh(input int base, input int n, input string tag);
        for (int k = 0; k < n; k++)
            chk($sformatf("%s[%0d]", tag, k), 32'(pulses[base + k]), 32'(exp_at(k)));
    endtask
    task automatic wait_count(input int n, input int budget, input string tag);
        int c = 0;
        while (pulses.size() < n && c < budget) begin
            @(negedge clock);
            #1;
            c++;
        end
        chk(tag, 32'(pulses.size() >= n), 32'd1);
    endtask
    task automatic wait_idle(input int budget, input string tag);
        int c = 0;
        while (feeder_busy && c < budget) begin
            @(negedge clock);
            #1;
            c++;
        end
        chk(tag, 32'(feeder_busy), 32'd0);
    endtask
    task automatic pulse_req();
        @(negedge clock);
        refresh_req = 1;
        @(negedge clock);
        refresh_req = 0;
    endtask
    initial begin
        int base;
        int w_cyc;
        for (int i = 0; i < 32; i++) exp_buf[i] = 8'h20;
        // reset and driver-init hold
        repeat (3) @(negedge clock);
        chk("rst_ready", 32'(lcd_data_ready), 32'd0);
        chk("rst_d", 32'(lcd_d), 32'd0);
        chk("rst_busy", 32'(feeder_busy), 32'd0);
        internal_reset_n = 1;
        repeat (200) @(negedge clock);
        chk("init_no_pulse", 32'(pulses.size()), 32'd0);
        chk("init_idle", 32'(feeder_busy), 32'd0);
        force_busy = 0;
        wait_count(1, 100, "t1_first");
        repeat (10) @(negedge clock);
        chk("t1_d_stable", 32'(lcd_d), 32'h080);
        wait_count(34, 4000, "t1_count");
        check_refresh(0, 34, "t1");
        wait_idle(200, "t1_idle");
        chk("t1_drv_idle", 32'(lcd_busy), 32'd0);
        repeat (100) @(negedge clock);
        chk("t1_no_extra", 32'(pulses.size()), 32'd34);
        // writes in idle
        base = pulses.size();
        @(negedge clock);
        wr_en = 1;
        wr_addr = 5;
        wr_data = 8'h41;
        w_cyc = cyc;
        @(negedge clock);
        wr_addr = 20;
        wr_data = 8'h39;
        @(negedge clock);
        wr_en = 0;
        exp_buf[5] = 8'h41;
        exp_buf[20] = 8'h39;
        wait_count(base + 68, 8000, "t2_count");
        chk("t2_latency", 32'(pcyc[base] - w_cyc), 32'd2);
        chk("t2_p7", 32'(pulses[base + 6]), 32'h141);
        chk("t2_p23", 32'(pulses[base + 22]), 32'h139);
        check_refresh(base, 34, "t2a");
        check_refresh(base + 34, 34, "t2b");
        wait_idle(200, "t2_idle");
        // write during a refresh
        base = pulses.size();
        pulse_req();
        wait_count(base + 10, 1000, "t3_p10");
        wr_en = 1;
        wr_addr = 31;
        wr_data = 8'h2B;
        @(negedge clock);
        wr_en = 0;
        wait_count(base + 34, 4000, "t3_first");
        check_refresh(base, 33, "t3a");
        exp_buf[31] = 8'h2B;
        wait_count(base + 68, 4000, "t3_second");
        check_refresh(base + 34, 34, "t3b");
        chk("t3_last", 32'(pulses[base + 67]), 32'h12B);
        wait_idle(200, "t3_idle");
        // acknowledge timeout
        base = pulses.size();
        ack_en = 0;
        pulse_req();
        wait_count(base + 1, 100, "t4_p1");
        wait_count(base + 2, ACK + 100, "t4_p2");
        chk("t4_gap1", 32'(pcyc[base + 1] - pcyc[base]), 32'(ACK + 1));
        wait_count(base + 3, ACK + 100, "t4_p3");
        chk("t4_gap2", 32'(pcyc[base + 2] - pcyc[base + 1]), 32'(ACK + 1));
        for (int k = 0; k < 3; k++) chk($sformatf("t4_d[%0d]", k), 32'(pulses[base + k]), 32'h080);
        repeat (500) @(negedge clock);
        chk("t4_hold_d", 32'(lcd_d), 32'h080);
        chk("t4_hold_ready", 32'(lcd_data_ready), 32'd0);
        ack_en = 1;
        wait_idle(6000, "t4_idle");
        chk("t4_total", 32'(pulses.size()), 32'(base + 37));
        // reset mid-refresh
        exp_buf[5] = 8'h41;
        base = pulses.size();
        pulse_req();
        wait_count(base + 20, 2000, "t5_p20");
        internal_reset_n = 0;
        @(negedge clock);
        chk("t5_ready", 32'(lcd_data_ready), 32'd0);
        chk("t5_d", 32'(lcd_d), 32'd0);
        chk("t5_busy", 32'(feeder_busy), 32'd0);
        repeat (5) @(negedge clock);
        internal_reset_n = 1;
        chk("t5_no_pulse", 32'(pulses.size()), 32'(base + 20));
        base = pulses.size();
        for (int i = 0; i < 32; i++) exp_buf[i] = 8'h20;
        wait_count(base + 34, 4000, "t5_count");
        check_refresh(base, 34, "t5");
        wait_idle(200, "t5_idle");
        // refresh_req in idle and during a refresh
        base = pulses.size();
        pulse_req();
        wait_count(base + 5, 1000, "t6_p5");
        pulse_req();
        wait_count(base + 68, 8000, "t6_count");
        check_refresh(base, 34, "t6a");
        check_refresh(base + 34, 34, "t6b");
        wait_idle(200, "t6_idle");
        repeat (200) @(negedge clock);
        chk("t6_no_extra", 32'(pulses.size()), 32'(base + 68));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
